// File: rtl/mdu_pkg.sv
// Shared constants for the multiply/divide sequencer:
// ALU control codes, FSM state encoding and op encoding.
package mdu_pkg;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_AND  = 4'd2;
   localparam logic [3:0] ALU_OR   = 4'd3;
   localparam logic [3:0] ALU_SLT  = 4'd4;
   localparam logic [3:0] ALU_SLTU = 4'd5;
   localparam logic [3:0] ALU_SLL  = 4'd6;
   localparam logic [3:0] ALU_LUI  = 4'd7;
   localparam logic [3:0] ALU_ORI  = 4'd8;

   typedef enum logic [2:0] {
      S_IDLE,
      S_M_ADD,
      S_M_CARRY,
      S_D_CMP,
      S_D_SUB,
      S_DONE
   } mdu_state_e;

   typedef enum logic {
      OP_MULTU = 1'b0,
      OP_DIVU  = 1'b1
   } mdu_op_e;

endpackage

// File: rtl/mdu_seq.sv
// Multi-cycle MULTU/DIVU sequencer; borrows the shared ALU
// for every add, subtract and unsigned compare it needs.
module mdu_seq
   import mdu_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic             op_i,
   input  logic [WIDTH-1:0] src1_i,
   input  logic [WIDTH-1:0] src2_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o,
   output logic             alu_req_o,
   output logic [WIDTH-1:0] alu_src1_o,
   output logic [WIDTH-1:0] alu_src2_o,
   output logic [3:0]       alu_ctrl_o,
   input  logic [WIDTH-1:0] alu_result_i
);

   localparam int CW = $clog2(WIDTH);

   mdu_state_e state_q, state_nxt;

   logic [WIDTH-1:0] a_q, a_nxt;
   logic [WIDTH-1:0] h_q, h_nxt;
   logic [WIDTH-1:0] l_q, l_nxt;
   logic [WIDTH-1:0] s_q, s_nxt;
   logic [CW-1:0]    cnt_q, cnt_nxt;

   logic [WIDTH-1:0] h_upd, l_upd;
   logic             m_step, d_step;
   logic             load_out;

   // Next-state, datapath update and ALU request decode
   always_comb begin
      state_nxt  = state_q;
      a_nxt      = a_q;
      h_nxt      = h_q;
      l_nxt      = l_q;
      s_nxt      = s_q;
      cnt_nxt    = cnt_q;
      h_upd      = h_q;
      l_upd      = l_q;
      m_step     = 1'b0;
      d_step     = 1'b0;
      alu_req_o  = 1'b0;
      alu_src1_o = '0;
      alu_src2_o = '0;
      alu_ctrl_o = 4'd0;

      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               if (op_i == OP_DIVU) begin
                  if (src2_i == '0) begin
                     h_nxt     = src1_i;
                     l_nxt     = '1;
                     state_nxt = S_DONE;
                  end else begin
                     a_nxt     = src2_i;
                     h_nxt     = {{(WIDTH-1){1'b0}},
                                  src1_i[WIDTH-1]};
                     l_nxt     = {src1_i[WIDTH-2:0], 1'b0};
                     cnt_nxt   = CW'(WIDTH-1);
                     state_nxt = S_D_CMP;
                  end
               end else begin
                  a_nxt     = src1_i;
                  l_nxt     = src2_i;
                  h_nxt     = '0;
                  cnt_nxt   = CW'(WIDTH-1);
                  state_nxt = S_M_ADD;
               end
            end
         end
         S_M_ADD: begin
            alu_req_o  = 1'b1;
            alu_src1_o = h_q;
            alu_src2_o = a_q;
            alu_ctrl_o = ALU_ADD;
            if (l_q[0]) begin
               s_nxt     = alu_result_i;
               state_nxt = S_M_CARRY;
            end else begin
               h_upd  = {1'b0, h_q[WIDTH-1:1]};
               l_upd  = {h_q[0], l_q[WIDTH-1:1]};
               m_step = 1'b1;
            end
         end
         S_M_CARRY: begin
            // Sum wrapped iff it ended up below the addend
            alu_req_o  = 1'b1;
            alu_src1_o = s_q;
            alu_src2_o = a_q;
            alu_ctrl_o = ALU_SLTU;
            h_upd  = {alu_result_i[0], s_q[WIDTH-1:1]};
            l_upd  = {s_q[0], l_q[WIDTH-1:1]};
            m_step = 1'b1;
         end
         S_D_CMP: begin
            alu_req_o  = 1'b1;
            alu_src1_o = h_q;
            alu_src2_o = a_q;
            alu_ctrl_o = ALU_SLTU;
            if (!alu_result_i[0]) begin
               state_nxt = S_D_SUB;
            end else begin
               d_step = 1'b1;
            end
         end
         S_D_SUB: begin
            alu_req_o  = 1'b1;
            alu_src1_o = h_q;
            alu_src2_o = a_q;
            alu_ctrl_o = ALU_SUB;
            h_upd  = alu_result_i;
            l_upd  = {l_q[WIDTH-1:1], 1'b1};
            d_step = 1'b1;
         end
         S_DONE: begin
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase

      if (m_step) begin
         h_nxt = h_upd;
         l_nxt = l_upd;
         if (cnt_q == '0) begin
            state_nxt = S_DONE;
         end else begin
            cnt_nxt   = cnt_q - CW'(1);
            state_nxt = S_M_ADD;
         end
      end

      if (d_step) begin
         if (cnt_q == '0) begin
            h_nxt     = h_upd;
            l_nxt     = l_upd;
            state_nxt = S_DONE;
         end else begin
            h_nxt     = {h_upd[WIDTH-2:0], l_upd[WIDTH-1]};
            l_nxt     = {l_upd[WIDTH-2:0], 1'b0};
            cnt_nxt   = cnt_q - CW'(1);
            state_nxt = S_D_CMP;
         end
      end
   end

   assign load_out = (state_nxt == S_DONE) &&
                     (state_q != S_DONE);
   assign busy_o   = (state_q != S_IDLE);
   assign done_o   = (state_q == S_DONE);

   // State and datapath registers; HI/LO captured on entry to DONE
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         h_q     <= '0;
         l_q     <= '0;
         s_q     <= '0;
         cnt_q   <= '0;
         hi_o    <= '0;
         lo_o    <= '0;
      end else begin
         state_q <= state_nxt;
         a_q     <= a_nxt;
         h_q     <= h_nxt;
         l_q     <= l_nxt;
         s_q     <= s_nxt;
         cnt_q   <= cnt_nxt;
         if (load_out) begin
            hi_o <= h_nxt;
            lo_o <= l_nxt;
         end
      end
   end

endmodule

// File: tb/tb_mdu_seq.sv
// Directed bench for mdu_seq with a behavioural shared ALU
// answering the sequencer's ALU requests.
module tb_mdu_seq;
   import mdu_pkg::*;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b0;
   logic        start_i = 1'b0;
   logic        op_i = 1'b0;
   logic [31:0] src1_i = '0;
   logic [31:0] src2_i = '0;
   logic        busy_o, done_o, alu_req_o;
   logic [31:0] hi_o, lo_o;
   logic [31:0] alu_src1_o, alu_src2_o, alu_result_i;
   logic [3:0]  alu_ctrl_o;

   int checks = 0;
   int errors = 0;
   int lat, busy_bad, req_cnt, pulses, first_done;

   mdu_seq #(.WIDTH(32)) dut (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .start_i(start_i),
      .op_i(op_i),
      .src1_i(src1_i),
      .src2_i(src2_i),
      .busy_o(busy_o),
      .done_o(done_o),
      .hi_o(hi_o),
      .lo_o(lo_o),
      .alu_req_o(alu_req_o),
      .alu_src1_o(alu_src1_o),
      .alu_src2_o(alu_src2_o),
      .alu_ctrl_o(alu_ctrl_o),
      .alu_result_i(alu_result_i)
   );

   always #5 clk_i = ~clk_i;

   // Shared datapath ALU, combinational
   always_comb begin
      alu_result_i = '0;
      case (alu_ctrl_o)
         ALU_ADD:  alu_result_i = alu_src1_o + alu_src2_o;
         ALU_SUB:  alu_result_i = alu_src1_o - alu_src2_o;
         ALU_SLTU: alu_result_i = {31'b0, alu_src1_o < alu_src2_o};
         default:  alu_result_i = '0;
      endcase
   end

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input logic op,
                         input logic [31:0] a,
                         input logic [31:0] b);
      @(negedge clk_i);
      start_i = 1'b1;
      op_i    = op;
      src1_i  = a;
      src2_i  = b;
      @(posedge clk_i);
      #1;
      start_i  = 1'b0;
      lat      = 1;
      busy_bad = 0;
      req_cnt  = 0;
      while (!done_o && lat < 200) begin
         if (!busy_o) busy_bad++;
         if (alu_req_o) req_cnt++;
         @(posedge clk_i);
         #1;
         lat++;
      end
      if (alu_req_o) req_cnt++;
   endtask

   task automatic after_done();
      chk("done_hi", {31'b0, done_o}, 32'd1);
      chk("busy_at_done", {31'b0, busy_o}, 32'd1);
      chk("req_at_done", {31'b0, alu_req_o}, 32'd0);
      chk("busy_gap", busy_bad, 0);
      @(posedge clk_i);
      #1;
      chk("done_pulse", {31'b0, done_o}, 32'd0);
      chk("idle_busy", {31'b0, busy_o}, 32'd0);
   endtask

   initial begin
      repeat (2) @(posedge clk_i);
      #1;
      chk("rst_busy", {31'b0, busy_o}, 32'd0);
      chk("rst_done", {31'b0, done_o}, 32'd0);
      chk("rst_req", {31'b0, alu_req_o}, 32'd0);
      chk("rst_hi", hi_o, 32'd0);
      chk("rst_lo", lo_o, 32'd0);
      chk("rst_src1", alu_src1_o, 32'd0);
      chk("rst_ctrl", {28'b0, alu_ctrl_o}, 32'd0);
      @(negedge clk_i);
      rst_i = 1'b1;

      run_op(1'b0, 32'd6, 32'd7);
      chk("mul6x7_lat", lat, 36);
      chk("mul6x7_lo", lo_o, 32'd42);
      chk("mul6x7_hi", hi_o, 32'd0);
      after_done();

      run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("mulmax_lat", lat, 65);
      chk("mulmax_hi", hi_o, 32'hFFFF_FFFE);
      chk("mulmax_lo", lo_o, 32'h0000_0001);
      after_done();

      run_op(1'b1, 32'd100, 32'd7);
      chk("div100_lat", lat, 36);
      chk("div100_lo", lo_o, 32'd14);
      chk("div100_hi", hi_o, 32'd2);
      after_done();

      run_op(1'b1, 32'hFFFF_FFFF, 32'hC000_0000);
      chk("divbig_lat", lat, 34);
      chk("divbig_lo", lo_o, 32'd1);
      chk("divbig_hi", hi_o, 32'h3FFF_FFFF);
      after_done();

      run_op(1'b1, 32'h1234, 32'd0);
      chk("div0_lat", lat, 1);
      chk("div0_hi", hi_o, 32'h1234);
      chk("div0_lo", lo_o, 32'hFFFF_FFFF);
      chk("div0_req", req_cnt, 0);
      after_done();
      chk("div0_req_after", {31'b0, alu_req_o}, 32'd0);

      // start held high with operands changing mid-operation
      @(negedge clk_i);
      start_i = 1'b1;
      op_i    = 1'b0;
      src1_i  = 32'd3;
      src2_i  = 32'd5;
      @(posedge clk_i);
      #1;
      op_i   = 1'b1;
      src1_i = 32'd9;
      src2_i = 32'd9;
      pulses = 0;
      first_done = 0;
      for (int n = 1; n <= 60; n++) begin
         if (done_o) begin
            pulses++;
            if (first_done == 0) first_done = n;
            start_i = 1'b0;
         end
         @(posedge clk_i);
         #1;
      end
      start_i = 1'b0;
      chk("hold_pulses", pulses, 1);
      chk("hold_lat", first_done, 35);
      chk("hold_lo", lo_o, 32'd15);
      chk("hold_hi", hi_o, 32'd0);

      // reset in the middle of a divide
      @(negedge clk_i);
      start_i = 1'b1;
      op_i    = 1'b1;
      src1_i  = 32'd1000;
      src2_i  = 32'd3;
      @(posedge clk_i);
      #1;
      start_i = 1'b0;
      repeat (9) @(posedge clk_i);
      @(negedge clk_i);
      chk("mid_busy", {31'b0, busy_o}, 32'd1);
      rst_i = 1'b0;
      @(posedge clk_i);
      #1;
      chk("abort_busy", {31'b0, busy_o}, 32'd0);
      chk("abort_req", {31'b0, alu_req_o}, 32'd0);
      chk("abort_hi", hi_o, 32'd0);
      chk("abort_lo", lo_o, 32'd0);
      @(negedge clk_i);
      rst_i = 1'b1;

      run_op(1'b0, 32'd2, 32'd3);
      chk("mul2x3_lat", lat, 35);
      chk("mul2x3_lo", lo_o, 32'd6);
      chk("mul2x3_hi", hi_o, 32'd0);
      after_done();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
